// File: rtl/keypad_matrix_scanner.sv
// 4x3 matrix keypad scanner: column drive, two-flop row synchronizer, scan snapshot and
// debounced press/release FSM. Define KEYPAD_SCAN_REPEAT_EN to enable auto-repeat pulses.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV       = 500,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned REPEAT_SCANS   = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [9:0] keypad,
    output logic       sharp,
    output logic       star,
    output logic [3:0] key_code,
    output logic       key_pulse
);

    localparam int unsigned DW     = $clog2(SCAN_DIV);
    localparam int unsigned CW     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [3:0]  NO_KEY = 4'hF;

    if (SCAN_DIV < 3) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 3");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must be at least 1");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("REPEAT_SCANS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_row_s1;
    logic [3:0]      r_row_s2;
    logic [DW-1:0]   r_dwell;
    logic [1:0]      r_col_idx;
    logic [2:0]      r_col;
    logic [11:0]     r_snap;
    logic [11:0]     w_snap_nxt;
    logic            w_dwell_last;
    logic            w_scan_end;
    logic [3:0]      w_n_closed;
    logic [3:0]      w_last_idx;
    logic [3:0]      w_scan_code;
    logic [3:0]      r_cand;
    logic [3:0]      w_cand_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic [3:0]      r_key_code;
    logic [3:0]      w_key_code_nxt;
    logic [11:0]     r_levels;
    logic [11:0]     w_levels_nxt;
    logic            r_pulse;
    logic            w_accept;
    logic            w_release_done;
    logic            w_rpt_fire;

    // Snapshot bit index is row*3 + col; the key map follows the keypad legend.
    function automatic logic [3:0] f_key_at(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd4;
            4'd4:    code = 4'd5;
            4'd5:    code = 4'd6;
            4'd6:    code = 4'd7;
            4'd7:    code = 4'd8;
            4'd8:    code = 4'd9;
            4'd9:    code = 4'd10;
            4'd10:   code = 4'd0;
            4'd11:   code = 4'd11;
            default: code = NO_KEY;
        endcase
        return code;
    endfunction

    function automatic logic [11:0] f_level(input logic [3:0] code);
        logic [11:0] lvl;
        lvl = '0;
        for (int unsigned k = 0; k < 12; k++) begin
            if (code == 4'(k)) lvl[k] = 1'b1;
        end
        return lvl;
    endfunction

    assign w_dwell_last = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_scan_end   = w_dwell_last && (r_col_idx == 2'd2);
    assign w_cnt_inc    = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    always_comb begin
        w_snap_nxt = r_snap;
        if (w_dwell_last) begin
            case (r_col_idx)
                2'd0:    {w_snap_nxt[9],  w_snap_nxt[6], w_snap_nxt[3], w_snap_nxt[0]} = ~r_row_s2;
                2'd1:    {w_snap_nxt[10], w_snap_nxt[7], w_snap_nxt[4], w_snap_nxt[1]} = ~r_row_s2;
                2'd2:    {w_snap_nxt[11], w_snap_nxt[8], w_snap_nxt[5], w_snap_nxt[2]} = ~r_row_s2;
                default: w_snap_nxt = r_snap;
            endcase
        end
    end

    // The col2 rows are folded in combinationally so the scan code is ready on the scan-end cycle.
    always_comb begin
        w_n_closed = '0;
        w_last_idx = '0;
        for (int unsigned k = 0; k < 12; k++) begin
            if (w_snap_nxt[k]) begin
                w_n_closed = w_n_closed + 4'd1;
                w_last_idx = 4'(k);
            end
        end
        w_scan_code = (w_n_closed == 4'd1) ? f_key_at(w_last_idx) : NO_KEY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dwell   <= '0;
            r_col_idx <= '0;
            r_col     <= 3'b110;
            r_snap    <= '0;
        end else begin
            r_snap <= w_snap_nxt;
            if (w_dwell_last) begin
                r_dwell   <= '0;
                r_col     <= {r_col[1:0], r_col[2]};
                r_col_idx <= (r_col_idx == 2'd2) ? 2'd0 : r_col_idx + 2'd1;
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand;
        w_cnt_nxt      = r_cnt;
        w_key_code_nxt = r_key_code;
        w_levels_nxt   = r_levels;
        w_accept       = 1'b0;
        w_release_done = 1'b0;
        if (w_scan_end) begin
            unique case (r_state)
                IDLE: begin
                    if (w_scan_code != NO_KEY) begin
                        w_cand_nxt = w_scan_code;
                        w_cnt_nxt  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) w_accept = 1'b1;
                        else                     w_state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (w_scan_code == r_cand) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CW'(DEBOUNCE_SCANS)) w_accept = 1'b1;
                    end else if (w_scan_code == NO_KEY) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cand_nxt = w_scan_code;
                        w_cnt_nxt  = CW'(1);
                    end
                end
                PRESSED: begin
                    if (w_scan_code != r_cand) begin
                        w_cnt_nxt = CW'(1);
                        if (DEBOUNCE_SCANS == 1) w_release_done = 1'b1;
                        else                     w_state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_scan_code != r_cand) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CW'(DEBOUNCE_SCANS)) w_release_done = 1'b1;
                    end else begin
                        w_state_nxt = PRESSED;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        if (w_accept) begin
            w_state_nxt    = PRESSED;
            w_key_code_nxt = w_cand_nxt;
            w_levels_nxt   = f_level(w_cand_nxt);
        end
        if (w_release_done) begin
            w_state_nxt    = IDLE;
            w_key_code_nxt = NO_KEY;
            w_levels_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cand     <= NO_KEY;
            r_cnt      <= '0;
            r_key_code <= NO_KEY;
            r_levels   <= '0;
            r_pulse    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cand     <= w_cand_nxt;
            r_cnt      <= w_cnt_nxt;
            r_key_code <= w_key_code_nxt;
            r_levels   <= w_levels_nxt;
            r_pulse    <= w_accept || w_rpt_fire;
        end
    end

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);

    logic [RW-1:0] r_rpt;
    logic [RW-1:0] w_rpt_inc;
    logic          w_rpt_hold;

    // Counter only advances while staying in PRESSED; any entry or exit leaves it cleared.
    assign w_rpt_hold = (r_state == PRESSED) && (w_state_nxt == PRESSED);
    assign w_rpt_inc  = r_rpt + RW'(1);
    assign w_rpt_fire = w_rpt_hold && w_scan_end && (w_rpt_inc == RW'(REPEAT_SCANS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rpt <= '0;
        end else if (!w_rpt_hold) begin
            r_rpt <= '0;
        end else if (w_scan_end) begin
            r_rpt <= w_rpt_fire ? '0 : w_rpt_inc;
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign col       = r_col;
    assign keypad    = r_levels[9:0];
    assign star      = r_levels[10];
    assign sharp     = r_levels[11];
    assign key_code  = r_key_code;
    assign key_pulse = r_pulse;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: keypad pin model, scan-history reference
// model compared every cycle, directed scenarios with literal expectations, then random presses.
module tb_keypad_matrix_scanner;

    localparam int SD   = 4;
    localparam int DS   = 3;
    localparam int RS   = 2;
    localparam int SCAN = 3 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] pressed = '0;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [9:0]  keypad;
    logic        sharp;
    logic        star;
    logic [3:0]  key_code;
    logic        key_pulse;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int tb_n;

    keypad_matrix_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DS),
        .REPEAT_SCANS(RS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .keypad(keypad),
        .sharp(sharp),
        .star(star),
        .key_code(key_code),
        .key_pulse(key_pulse)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) tb_n <= 0;
        else      tb_n <= tb_n + 1;
    end

    // Reference model: per-scan codes from sampled pin history, acceptance/release from windows.
    int          keymap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    logic [11:0] hist [12];
    int          codes [$];
    int          held = 15;
    int          acc_scan = -1;
    int          rel_scan = -1;

    function automatic int model_code();
        int nk = 0;
        int k = 15;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                if (hist[4*c+1][r*3+c]) begin
                    nk++;
                    k = keymap[r*3+c];
                end
        return (nk == 1) ? k : 15;
    endfunction

    function automatic bit window_all(int j, int key, bit eq);
        for (int i = j - DS + 1; i <= j; i++)
            if ((codes[i] == key) != eq) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_scan(input int j, output bit pulse);
        pulse = 1'b0;
        if (held == 15) begin
            if (j - DS + 1 > rel_scan && codes[j] != 15 && window_all(j, codes[j], 1'b1)) begin
                held = codes[j];
                acc_scan = j;
                pulse = 1'b1;
            end
        end else if (j - DS + 1 > acc_scan && window_all(j, held, 1'b0)) begin
            held = 15;
            rel_scan = j;
        end else if (codes[j] == held) begin
`ifdef KEYPAD_SCAN_REPEAT_EN
            int s = j;
            int counted;
            while (s > acc_scan + 1 && codes[s-1] == held) s--;
            counted = (s == acc_scan + 1) ? (j - s + 1) : (j - s);
            if (counted > 0 && counted % RS == 0) pulse = 1'b1;
`endif
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] exp_v;
        logic [19:0] act_v;
        logic [2:0]  exp_col;
        logic [9:0]  exp_kp;
        bit          p;
        p = 1'b0;
        if (!rst) begin
            held = 15;
            acc_scan = -1;
            rel_scan = -1;
            codes.delete();
            exp_v = {3'b110, 10'b0, 1'b0, 1'b0, 4'hF, 1'b0};
        end else begin
            hist[tb_n % SCAN] = pressed;
            if (tb_n > 0 && tb_n % SCAN == 0) begin
                codes.push_back(model_code());
                model_scan(tb_n / SCAN - 1, p);
            end
            exp_col = 3'b111 ^ (3'b001 << ((tb_n / SD) % 3));
            exp_kp  = (held < 10) ? 10'(1 << held) : 10'b0;
            exp_v   = {exp_col, exp_kp, held == 10, held == 11, 4'(held), p};
        end
        act_v = {col, keypad, star, sharp, key_code, key_pulse};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %h expected %h {col,keypad,star,sharp,code,pulse}",
                     tb_n, act_v, exp_v);
        end
        if (rst && key_pulse) pulses++;
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic to_scan_start();
        int g = 0;
        while (tb_n % SCAN != 0 && g < 2 * SCAN) begin
            tick(1);
            g++;
        end
        check("scan_align", tb_n % SCAN, 0);
    endtask

    initial begin
        int p0;
        int a;
        int b;
        rst = 1'b0;
        pressed = '0;
        tick(3);
        check("reset_col", col, 3'b110);
        check("reset_keypad", keypad, 0);
        check("reset_code", key_code, 15);
        check("reset_pulse", key_pulse, 0);

        rst = 1'b1;
        check("col_n0", col, 3'b110);
        tick(4);
        check("col_n4", col, 3'b101);
        tick(4);
        check("col_n8", col, 3'b011);
        tick(4);
        check("col_n12", col, 3'b110);

        // key 5 press and release
        p0 = pulses;
        to_scan_start();
        pressed = 12'(1) << 4;
        tick(3 * SCAN - 1);
        check("k5_code_before", key_code, 15);
        check("k5_pulse_before", key_pulse, 0);
        tick(1);
        check("k5_pulse", key_pulse, 1);
        check("k5_keypad", keypad, 10'b0000100000);
        check("k5_code", key_code, 5);
        tick(1);
        check("k5_pulse_once", key_pulse, 0);
        to_scan_start();
        pressed = '0;
        tick(3 * SCAN - 1);
        check("k5_held_until_release", keypad, 10'b0000100000);
        tick(1);
        check("k5_released", keypad, 0);
        check("k5_released_code", key_code, 15);
        check("k5_pulse_count", pulses - p0, 1);

        // bounce on key 8
        p0 = pulses;
        to_scan_start();
        pressed = 12'(1) << 7;
        tick(SCAN);
        pressed = '0;
        tick(SCAN);
        pressed = 12'(1) << 7;
        tick(SCAN);
        pressed = '0;
        tick(4 * SCAN);
        check("bounce_pulses", pulses - p0, 0);
        check("bounce_keypad", keypad, 0);
        check("bounce_code", key_code, 15);

        // keys 1 and 3 together, then 3 alone
        to_scan_start();
        pressed = (12'(1) << 0) | (12'(1) << 2);
        tick(4 * SCAN);
        check("two_key_code", key_code, 15);
        pressed = 12'(1) << 2;
        tick(3 * SCAN - 1);
        check("k3_code_before", key_code, 15);
        tick(1);
        check("k3_code", key_code, 3);
        check("k3_pulse", key_pulse, 1);
        pressed = '0;
        tick(5 * SCAN);

        // sharp held, reset mid-hold, re-acceptance
        to_scan_start();
        pressed = 12'(1) << 11;
        tick(3 * SCAN);
        check("sharp_level", sharp, 1);
        check("sharp_keypad", keypad, 0);
        check("sharp_code", key_code, 11);
        tick(20);
        #2;
        rst = 1'b0;
        #1;
        check("sharp_async_clear", sharp, 0);
        check("sharp_async_code", key_code, 15);
        check("sharp_async_pulse", key_pulse, 0);
        check("sharp_async_col", col, 3'b110);
        tick(3);
        rst = 1'b1;
        tick(3 * SCAN - 1);
        check("sharp_reacc_before", sharp, 0);
        tick(1);
        check("sharp_reacc", sharp, 1);
        check("sharp_reacc_pulse", key_pulse, 1);
        pressed = '0;
        tick(5 * SCAN);

        // key 0 held for ten scans
        p0 = pulses;
        to_scan_start();
        pressed = 12'(1) << 10;
        tick(3 * SCAN);
        check("k0_keypad", keypad, 1);
        check("k0_code", key_code, 0);
        tick(7 * SCAN);
        pressed = '0;
        tick(5 * SCAN);
`ifdef KEYPAD_SCAN_REPEAT_EN
        check("k0_pulses", pulses - p0, 4);
`else
        check("k0_pulses", pulses - p0, 1);
`endif
        check("k0_released", key_code, 15);

        // random presses, bounces and multi-key overlaps
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pressed = '0;
                4, 5, 6, 7: pressed = 12'(1) << $urandom_range(0, 11);
                8: begin
                    a = int'($urandom_range(0, 11));
                    b = int'($urandom_range(0, 11));
                    pressed = (12'(1) << a) | (12'(1) << b);
                end
                default: pressed = pressed;
            endcase
            if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(30, 80)));
            else                           tick(int'($urandom_range(1, 15)));
        end
        pressed = '0;
        tick(6 * SCAN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
